// File: rtl/async_event_sync_multi.sv
// Multi-channel event synchronizer: per-channel flop chain, edge detect, one-cycle pulse
// and a saturating pending-event counter with sticky overflow, all in the rx_clk domain.
module async_event_sync_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic                    rx_clk,
  input  logic                    rx_rst,
  input  logic [NUM_CH-1:0]       async_in,
  output logic [NUM_CH-1:0]       evt_pulse,
  output logic [NUM_CH-1:0]       evt_pending,
  input  logic [NUM_CH-1:0]       evt_ack,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt,
  output logic [NUM_CH-1:0]       ovf,
  input  logic [NUM_CH-1:0]       ovf_clr
);

  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("async_event_sync_multi: EDGE_MODE must be 0, 1 or 2");
  end
  if (NUM_CH < 1 || SYNC_STAGES < 2 || CNT_W < 1) begin : g_bad_sizes
    $error("async_event_sync_multi: NUM_CH>=1, SYNC_STAGES>=2, CNT_W>=1 required");
  end

  // Detection stays masked until the chain and delay flop hold real post-reset samples.
  localparam int WARM   = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM + 1);

  logic [WARM_W-1:0] warm_reg;
  logic              armed;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      warm_reg <= WARM_W'(WARM);
    end else if (warm_reg != '0) begin
      warm_reg <= warm_reg - 1'b1;
    end
  end

  assign armed = (warm_reg == '0);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   d_reg;
    logic                   s;
    logic                   edge_raw;
    logic                   evt_hit;
    logic                   ack_ok;
    logic                   at_max;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   pulse_reg;
    logic                   ovf_reg;

    assign s = sync_reg[SYNC_STAGES-1];

    if (EDGE_MODE == 1) begin : g_rise
      assign edge_raw = s & ~d_reg;
    end else if (EDGE_MODE == 2) begin : g_fall
      assign edge_raw = ~s & d_reg;
    end else begin : g_any
      assign edge_raw = s ^ d_reg;
    end

    assign evt_hit = edge_raw & armed;
    // An ack against an empty counter is simply dropped so the count never wraps.
    assign ack_ok  = evt_ack[gi] & (cnt_reg != '0);
    assign at_max  = &cnt_reg;

    always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
        sync_reg  <= '0;
        d_reg     <= 1'b0;
        pulse_reg <= 1'b0;
        cnt_reg   <= '0;
        ovf_reg   <= 1'b0;
      end else begin
        sync_reg  <= {sync_reg[SYNC_STAGES-2:0], async_in[gi]};
        d_reg     <= s;
        pulse_reg <= evt_hit;
        if (evt_hit && !ack_ok) begin
          if (!at_max) cnt_reg <= cnt_reg + 1'b1;
        end else if (!evt_hit && ack_ok) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
        // A new overflow outranks a same-cycle clear so no overflow goes unreported.
        if (evt_hit && !ack_ok && at_max) begin
          ovf_reg <= 1'b1;
        end else if (ovf_clr[gi]) begin
          ovf_reg <= 1'b0;
        end
      end
    end

    assign evt_pulse[gi]                = pulse_reg;
    assign evt_cnt[gi*CNT_W +: CNT_W]   = cnt_reg;
    assign evt_pending[gi]              = (cnt_reg != '0);
    assign ovf[gi]                      = ovf_reg;
  end

endmodule

// File: tb/tb_async_event_sync_multi.sv
// Bench for async_event_sync_multi: three instances (rising/any/falling modes) share stimulus;
// pulses are checked cycle-exactly against a scoreboard, counts against table constants.
module tb_async_event_sync_multi;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [3:0]  async_in;
  logic [3:0]  evt_ack;
  logic [3:0]  ovf_clr;

  logic [3:0]  pulse_m0, pulse_m1, pulse_m2;
  logic [3:0]  pend_m0, pend_m1, pend_m2;
  logic [15:0] cnt_m0, cnt_m1, cnt_m2;
  logic [3:0]  ovf_m0, ovf_m1, ovf_m2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [3:0]  in;
    logic [3:0]  p0, p1, p2;
    logic [15:0] c0, c1, c2;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] p0, p1, p2;
  } exp_t;

  vec_t tbl[5];
  exp_t sb_q[$];

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  async_event_sync_multi #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(4), .EDGE_MODE(0)) u_m0 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .async_in(async_in), .evt_pulse(pulse_m0),
    .evt_pending(pend_m0), .evt_ack(evt_ack), .evt_cnt(cnt_m0), .ovf(ovf_m0), .ovf_clr(ovf_clr));
  async_event_sync_multi #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(4), .EDGE_MODE(1)) u_m1 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .async_in(async_in), .evt_pulse(pulse_m1),
    .evt_pending(pend_m1), .evt_ack(evt_ack), .evt_cnt(cnt_m1), .ovf(ovf_m1), .ovf_clr(ovf_clr));
  async_event_sync_multi #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(4), .EDGE_MODE(2)) u_m2 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .async_in(async_in), .evt_pulse(pulse_m2),
    .evt_pending(pend_m2), .evt_ack(evt_ack), .evt_cnt(cnt_m2), .ovf(ovf_m2), .ovf_clr(ovf_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pend_of(input logic [15:0] c);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = (c[i*4 +: 4] != 4'd0);
    return p;
  endfunction

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Flip one channel; the pulse is due SYNC_STAGES edges after the capturing edge.
  task automatic toggle_ch(input int ch);
    logic       nv;
    logic [3:0] m;
    exp_t       e;
    m            = 4'b0001 << ch;
    nv           = ~async_in[ch];
    async_in[ch] = nv;
    e.cyc = cyc + 3;
    e.p0  = m;
    e.p1  = nv ? m : 4'b0000;
    e.p2  = nv ? 4'b0000 : m;
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_m0"}, 32'(cnt_m0), 32'h0);
    chk({tag, "_cnt_m1"}, 32'(cnt_m1), 32'h0);
    chk({tag, "_cnt_m2"}, 32'(cnt_m2), 32'h0);
    chk({tag, "_pulse"}, 32'({pulse_m0, pulse_m1, pulse_m2}), 32'h0);
    chk({tag, "_pend"}, 32'({pend_m0, pend_m1, pend_m2}), 32'h0);
    chk({tag, "_ovf"}, 32'({ovf_m0, ovf_m1, ovf_m2}), 32'h0);
  endtask

  // Scoreboard: every cycle the pulses must equal the queued expectation for that cycle, else 0.
  always @(negedge rx_clk) begin
    if (mon_en) begin : mon
      logic [3:0] e0, e1, e2;
      e0 = 4'b0; e1 = 4'b0; e2 = 4'b0;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL pulse_missed: expected pulse at cycle %0d not consumed by cycle %0d", sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e0 = sb_q[0].p0; e1 = sb_q[0].p1; e2 = sb_q[0].p2;
        void'(sb_q.pop_front());
      end
      chk("pulse_m0", 32'(pulse_m0), 32'(e0));
      chk("pulse_m1", 32'(pulse_m1), 32'(e1));
      chk("pulse_m2", 32'(pulse_m2), 32'(e2));
    end
  end

  initial begin
    exp_t e;
    // {in, pulse m0/m1/m2, cnt m0/m1/m2 after the row}; each row holds its level 5 cycles.
    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0001, 16'h0001, 16'h0000};
    tbl[1] = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 16'h0011, 16'h0011, 16'h0000};
    tbl[2] = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 16'h0021, 16'h0011, 16'h0010};
    tbl[3] = '{4'b1110, 4'b1111, 4'b1110, 4'b0001, 16'h1132, 16'h1121, 16'h0011};
    tbl[4] = '{4'b0000, 4'b1110, 4'b0000, 4'b1110, 16'h2242, 16'h1121, 16'h1121};

    rx_rst   = 1'b1;
    async_in = 4'b0;
    evt_ack  = 4'b0;
    ovf_clr  = 4'b0;
    ticks(3);
    chk_all_zero("reset");
    mon_en = 1'b1;
    rx_rst = 1'b0;
    ticks(4);

    for (int r = 0; r < 5; r++) begin
      async_in = tbl[r].in;
      e.cyc = cyc + 3; e.p0 = tbl[r].p0; e.p1 = tbl[r].p1; e.p2 = tbl[r].p2;
      sb_q.push_back(e);
      ticks(5);
      chk("row_cnt_m0", 32'(cnt_m0), 32'(tbl[r].c0));
      chk("row_cnt_m1", 32'(cnt_m1), 32'(tbl[r].c1));
      chk("row_cnt_m2", 32'(cnt_m2), 32'(tbl[r].c2));
      chk("row_pend_m0", 32'(pend_m0), 32'(pend_of(tbl[r].c0)));
      chk("row_pend_m2", 32'(pend_m2), 32'(pend_of(tbl[r].c2)));
      $display("row %0d: in=%b cnt_m0=%h cnt_m1=%h cnt_m2=%h", r, tbl[r].in, cnt_m0, cnt_m1, cnt_m2);
    end

    // One ack on every channel, then a long ack that must stop at zero.
    evt_ack = 4'b1111;
    tick();
    evt_ack = 4'b0000;
    chk("ack1_cnt_m0", 32'(cnt_m0), 32'h1131);
    chk("ack1_cnt_m1", 32'(cnt_m1), 32'h0010);
    chk("ack1_cnt_m2", 32'(cnt_m2), 32'h0010);
    evt_ack = 4'b1111;
    ticks(5);
    evt_ack = 4'b0000;
    tick();
    chk_all_zero("drain");
    $display("ack: drained cnt_m0=%h", cnt_m0);

    // Saturation and sticky overflow on channel 2.
    for (int k = 0; k < 15; k++) begin toggle_ch(2); ticks(3); end
    tick();
    chk("sat15_cnt", 32'(cnt_m0[11:8]), 32'd15);
    chk("sat15_ovf", 32'(ovf_m0), 32'h0);
    toggle_ch(2);
    ticks(4);
    chk("sat16_cnt", 32'(cnt_m0[11:8]), 32'd15);
    chk("sat16_ovf", 32'(ovf_m0), 32'h4);
    chk("sat16_cnt_m1", 32'(cnt_m1[11:8]), 32'd8);
    toggle_ch(2);
    ticks(2);
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = 4'b0000;
    chk("setwins_ovf", 32'(ovf_m0), 32'h4);
    chk("setwins_cnt", 32'(cnt_m0[11:8]), 32'd15);
    ticks(2);
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = 4'b0000;
    chk("ovfclr_ovf", 32'(ovf_m0), 32'h0);
    $display("overflow: ch2 cnt=%0d ovf=%b", cnt_m0[11:8], ovf_m0);

    // Event and ack in the same cycle on a full channel 3.
    for (int k = 0; k < 15; k++) begin toggle_ch(3); ticks(3); end
    tick();
    chk("ch3_full_cnt", 32'(cnt_m0[15:12]), 32'd15);
    toggle_ch(3);
    ticks(2);
    evt_ack = 4'b1000;
    tick();
    evt_ack = 4'b0000;
    tick();
    chk("evtack_cnt", 32'(cnt_m0[15:12]), 32'd15);
    chk("evtack_ovf", 32'(ovf_m0[3]), 32'd0);
    chk("evtack_cnt_m1", 32'(cnt_m1[15:12]), 32'd7);
    chk("evtack_cnt_m2", 32'(cnt_m2[15:12]), 32'd7);
    $display("evt+ack: ch3 cnt=%0d ovf=%b", cnt_m0[15:12], ovf_m0);

    // Reset mid-stream with ch0 = 7, then warm-up before the next toggle counts.
    for (int k = 0; k < 7; k++) begin toggle_ch(0); ticks(3); end
    tick();
    chk("pre_rst_cnt", 32'(cnt_m0[3:0]), 32'd7);
    #3 rx_rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    ticks(2);
    rx_rst = 1'b0;
    ticks(5);
    chk("post_rst_cnt_m0", 32'(cnt_m0), 32'h0);
    chk("post_rst_cnt_m1", 32'(cnt_m1), 32'h0);
    toggle_ch(0);
    ticks(4);
    chk("post_rst_evt_m0", 32'(cnt_m0), 32'h0001);
    chk("post_rst_evt_m1", 32'(cnt_m1), 32'h0000);
    chk("post_rst_evt_m2", 32'(cnt_m2), 32'h0001);
    $display("midreset: cnt_m0=%h after first post-warm-up toggle", cnt_m0);

    // Levels held high through reset must not produce events.
    rx_rst = 1'b1;
    async_in = 4'b1111;
    ticks(2);
    rx_rst = 1'b0;
    ticks(8);
    chk_all_zero("held");
    $display("held-through-reset: cnt_m0=%h cnt_m1=%h", cnt_m0, cnt_m1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
